// File: rtl/led_pkg.sv
// led_pkg: mode encodings and channel-index width shared by the LED pattern generator
package led_pkg;
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;
  localparam int CHAN_W = 4;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel counting prescaler ticks to produce OFF/ON/BLINK/PULSE state
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W = 8
) (
  input  logic             OSCIN,
  input  logic             RST,
  input  logic             tick,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [PER_W-1:0] half,
  output logic             state
);
  logic [1:0]       r_mode;
  logic [PER_W-1:0] r_half;
  logic [PER_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_run;
  logic             w_end;
  assign w_run = (r_mode == MODE_BLINK) || (r_mode == MODE_PULSE);
  assign w_end = r_cnt == r_half - PER_W'(1);
  assign state = (r_mode == MODE_ON) || (w_run && r_phase);
  // a load overrides a coincident tick; running modes advance one count per tick
  always_ff @(posedge OSCIN or posedge RST)
    if (RST) begin
      r_mode  <= MODE_OFF;
      r_half  <= PER_W'(1);
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (load) begin
      r_mode  <= mode;
      r_half  <= (half == '0) ? PER_W'(1) : half;
      r_cnt   <= '0;
      r_phase <= (mode == MODE_BLINK) || (mode == MODE_PULSE);
    end else if (tick && w_run) begin
      r_cnt <= w_end ? '0 : r_cnt + PER_W'(1);
      if (w_end) begin
        r_phase <= (r_mode == MODE_BLINK) ? !r_phase : 1'b0;
        if (r_mode == MODE_PULSE) r_mode <= MODE_OFF;
      end
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NCH-channel LED pattern generator with shared prescaler and valid/ready config; LED_DIM_EN adds PWM dimming
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 1000000,
  parameter int PER_W    = 8
) (
  input  logic              OSCIN,
  input  logic              RST,
`ifdef LED_DIM_EN
  input  logic [3:0]        dim,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_half,
  output logic              tick,
  output logic [NCH-1:0]    LED
);
  localparam int PRE_W = $clog2(PRESCALE);
  logic [PRE_W-1:0] r_pre;
  logic             r_ready;
  logic [NCH-1:0]   r_led;
  logic [NCH-1:0]   w_state;
  logic [NCH-1:0]   w_load;
  logic [NCH-1:0]   w_led;
  logic             w_tick;
  logic             w_xfer;
  assign w_tick    = r_pre == PRE_W'(PRESCALE - 1);
  assign w_xfer    = cfg_valid && r_ready;
  assign tick      = w_tick;
  assign cfg_ready = r_ready;
  assign LED       = r_led;
  // free-running prescaler, independent of config traffic
  always_ff @(posedge OSCIN or posedge RST)
    if (RST) r_pre <= '0;
    else r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  // ready drops for exactly one cycle after each accepted transfer
  always_ff @(posedge OSCIN or posedge RST)
    if (RST) r_ready <= 1'b1;
    else r_ready <= !w_xfer;
  genvar c;
  for (c = 0; c < NCH; c++) begin : g_ch
    assign w_load[c] = w_xfer && (cfg_chan == CHAN_W'(c));
    led_channel #(.PER_W(PER_W)) u_ch (
      .OSCIN(OSCIN),
      .RST  (RST),
      .tick (w_tick),
      .load (w_load[c]),
      .mode (cfg_mode),
      .half (cfg_half),
      .state(w_state[c])
    );
  end
`ifdef LED_DIM_EN
  logic [3:0] r_pwm;
  logic       w_dim_ok;
  assign w_dim_ok = (dim == 4'd15) || (r_pwm < dim);
  assign w_led    = w_state & {NCH{w_dim_ok}};
  // free-running PWM phase for dimming
  always_ff @(posedge OSCIN or posedge RST)
    if (RST) r_pwm <= '0;
    else r_pwm <= r_pwm + 4'd1;
`else
  assign w_led = w_state;
`endif
  // registered LED drive
  always_ff @(posedge OSCIN or posedge RST)
    if (RST) r_led <= '0;
    else r_led <= w_led;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (NCH=4, PRESCALE=4, PER_W=8); LED_DIM_EN adds dim tests
module tb_led_pattern_gen;
  import led_pkg::*;
  localparam int NCH = 4;
  localparam int PRESCALE = 4;
  localparam int PER_W = 8;
  logic OSCIN = 1'b0;
  logic RST = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic tick;
  logic [3:0] cfg_chan = '0;
  logic [1:0] cfg_mode = '0;
  logic [PER_W-1:0] cfg_half = '0;
  logic [NCH-1:0] LED;
`ifdef LED_DIM_EN
  logic [3:0] dim = 4'd15;
`endif
  int checks = 0;
  int failures = 0;
  string tname = "init";
  logic [NCH-1:0] sb[$];
  int m_pre, m_pwm;
  logic m_ready;
  logic [1:0] m_mode[NCH];
  int m_half[NCH];
  int m_n[NCH];

  led_pattern_gen #(.NCH(NCH), .PRESCALE(PRESCALE), .PER_W(PER_W)) dut (
    .OSCIN(OSCIN),
    .RST(RST),
`ifdef LED_DIM_EN
    .dim(dim),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode),
    .cfg_half(cfg_half),
    .tick(tick),
    .LED(LED)
  );

  always #5 OSCIN = ~OSCIN;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // LED value implied by the ticks counted since each channel's last load
  function automatic logic [NCH-1:0] model_led();
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      case (m_mode[i])
        MODE_ON:    v[i] = 1'b1;
        MODE_BLINK: v[i] = ((m_n[i] / m_half[i]) % 2) == 0;
        MODE_PULSE: v[i] = m_n[i] < m_half[i];
        default:    v[i] = 1'b0;
      endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_pwm = 0;
    m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = MODE_OFF;
      m_half[i] = 1;
      m_n[i] = 0;
    end
    sb.delete();
  endtask

  // one clock: push expected LED, advance the model, then pop and compare after the edge
  task automatic cycle();
    logic [NCH-1:0] exp;
    logic xfer, tk;
    exp = model_led();
`ifdef LED_DIM_EN
    if (!(dim == 4'd15 || m_pwm < int'(dim))) exp = '0;
    m_pwm = (m_pwm + 1) % 16;
`endif
    sb.push_back(exp);
    xfer = cfg_valid && m_ready;
    tk = (m_pre == PRESCALE - 1);
    for (int i = 0; i < NCH; i++)
      if (xfer && int'(cfg_chan) == i) begin
        m_mode[i] = cfg_mode;
        m_half[i] = (cfg_half == '0) ? 1 : int'(cfg_half);
        m_n[i] = 0;
      end else if (tk && (m_mode[i] == MODE_BLINK || m_mode[i] == MODE_PULSE)) m_n[i]++;
    m_pre = tk ? 0 : m_pre + 1;
    m_ready = !xfer;
    @(posedge OSCIN);
    #1;
    exp = sb.pop_front();
    checks++;
    if (LED !== exp) begin
      failures++;
      $display("FAIL %s led: got %b want %b", tname, LED, exp);
    end
    checks++;
    if (tick !== (m_pre == PRESCALE - 1)) begin
      failures++;
      $display("FAIL %s tick: got %b want %0d", tname, tick, m_pre == PRESCALE - 1);
    end
    checks++;
    if (cfg_ready !== m_ready) begin
      failures++;
      $display("FAIL %s ready: got %b want %b", tname, cfg_ready, m_ready);
    end
  endtask

  task automatic send(input int ch, input logic [1:0] md, input int hf);
    cfg_chan = 4'(ch);
    cfg_mode = md;
    cfg_half = PER_W'(hf);
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    int nt;
    tname = "reset";
    nt = 0;
    repeat (2) @(posedge OSCIN);
    #1;
    checks += 3;
    if (LED !== '0) begin failures++; $display("FAIL reset led: got %b want 0", LED); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset ready: got %b want 1", cfg_ready); end
    if (tick !== 1'b0) begin failures++; $display("FAIL reset tick: got %b want 0", tick); end
    RST = 1'b0;
    model_reset();
    repeat (8) begin
      cycle();
      if (tick) nt++;
    end
    checks++;
    if (nt != 2) begin failures++; $display("FAIL reset tick_count: got %0d want 2", nt); end
  endtask

  task automatic test_blink();
    logic b[50];
    int runs[$];
    int len;
    tname = "blink";
    cfg_chan = 4'd1;
    cfg_mode = MODE_BLINK;
    cfg_half = 8'd3;
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    for (int j = 0; j < 50; j++) begin
      cycle();
      b[j] = LED[1];
    end
    len = 1;
    for (int j = 1; j < 50; j++)
      if (b[j] == b[j-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    checks++;
    if (b[0] !== 1'b1) begin failures++; $display("FAIL blink first: got %b want 1", b[0]); end
    checks++;
    if (runs.size() < 3) begin
      failures++;
      $display("FAIL blink runs: got %0d runs want >=3", runs.size());
    end else begin
      checks += 2;
      if (runs[0] < 9 || runs[0] > 12) begin failures++; $display("FAIL blink phase0: got %0d want 9..12", runs[0]); end
      if (runs[1] != 12 || runs[2] != 12) begin
        failures++;
        $display("FAIL blink phase_len: got %0d,%0d want 12,12", runs[1], runs[2]);
      end
    end
  endtask

  task automatic test_pulse();
    int hi;
    tname = "pulse";
    hi = 0;
    cfg_chan = 4'd2;
    cfg_mode = MODE_PULSE;
    cfg_half = 8'd2;
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    repeat (20) begin
      cycle();
      if (LED[2]) hi++;
    end
    checks += 2;
    if (hi < 5 || hi > 8) begin failures++; $display("FAIL pulse width: got %0d want 5..8", hi); end
    if (LED[2] !== 1'b0) begin failures++; $display("FAIL pulse end: got %b want 0", LED[2]); end
    send(2, MODE_ON, 1);
    checks++;
    if (LED[2] !== 1'b1) begin failures++; $display("FAIL pulse then_on: got %b want 1", LED[2]); end
  endtask

  task automatic test_handshake();
    int chs[6] = '{0, 1, 2, 3, 9, 0};
    logic [1:0] mds[6] = '{MODE_ON, MODE_ON, MODE_BLINK, MODE_ON, MODE_ON, MODE_OFF};
    logic rdy_want[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int acc;
    tname = "handshake";
    acc = 0;
    cfg_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cfg_chan = 4'(chs[j]);
      cfg_mode = mds[j];
      cfg_half = 8'd2;
      checks++;
      if (cfg_ready !== rdy_want[j]) begin
        failures++;
        $display("FAIL handshake ready[%0d]: got %b want %b", j, cfg_ready, rdy_want[j]);
      end
      if (cfg_ready) acc++;
      cycle();
    end
    cfg_valid = 1'b0;
    cycle();
    checks++;
    if (acc != 3) begin failures++; $display("FAIL handshake accepted: got %0d want 3", acc); end
    send(1, MODE_OFF, 1);
    send(2, MODE_OFF, 1);
    send(9, MODE_ON, 1);
    repeat (2) cycle();
    checks++;
    if (LED !== 4'b0001) begin failures++; $display("FAIL handshake chan9: got %b want 0001", LED); end
  endtask

  task automatic test_collision();
    int run;
    tname = "collision";
    run = 0;
    send(0, MODE_BLINK, 2);
    for (int j = 0; j < 4 && m_pre != PRESCALE - 1; j++) cycle();
    checks++;
    if (tick !== 1'b1) begin failures++; $display("FAIL collision tick_align: got %b want 1", tick); end
    cfg_chan = 4'd3;
    cfg_mode = MODE_BLINK;
    cfg_half = 8'd0;
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (LED[3]) run++;
      else break;
    end
    checks++;
    if (run != 4) begin failures++; $display("FAIL collision first_phase: got %0d want 4", run); end
    repeat (16) cycle();
  endtask

  task automatic test_async_reset();
    tname = "async_reset";
    send(1, MODE_BLINK, 3);
    repeat (5) cycle();
    #3;
    RST = 1'b1;
    #1;
    checks += 3;
    if (LED !== '0) begin failures++; $display("FAIL async_reset led: got %b want 0", LED); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL async_reset ready: got %b want 1", cfg_ready); end
    if (tick !== 1'b0) begin failures++; $display("FAIL async_reset tick: got %b want 0", tick); end
    @(posedge OSCIN);
    #1;
    RST = 1'b0;
    model_reset();
    repeat (10) cycle();
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim();
    int hi;
    tname = "dim";
    hi = 0;
    for (int i = 0; i < NCH; i++) send(i, MODE_ON, 1);
    dim = 4'd4;
    repeat (32) begin
      cycle();
      if (LED[0]) hi++;
    end
    checks++;
    if (hi != 8) begin failures++; $display("FAIL dim duty: got %0d want 8", hi); end
    dim = 4'd0;
    repeat (3) cycle();
    checks++;
    if (LED !== '0) begin failures++; $display("FAIL dim zero: got %b want 0", LED); end
    dim = 4'd15;
    repeat (2) cycle();
    checks++;
    if (LED !== '1) begin failures++; $display("FAIL dim full: got %b want 1111", LED); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_blink();
    test_pulse();
    test_handshake();
    test_collision();
    test_async_reset();
`ifdef LED_DIM_EN
    test_dim();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
